// File: rtl/seq_mul.sv
// seq_mul: shift-and-add multiplier, one multiplier bit per clock, double-width product.
// Define SEQ_MUL_SIGNED_EN to honour signed_op (magnitude multiply plus a FIX negation step).
module seq_mul #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic            signed_op,
   input  logic            start,
   output logic [BITS-1:0] p,
   output logic [BITS-1:0] hi,
   output logic            ovf,
   output logic            rdy
);
   localparam int IW = (BITS > 2) ? $clog2(BITS) : 1;
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;
   logic [BITS-1:0] a_q, b_q, a_in, b_in;
   logic [2*BITS-1:0] acc, acc_add, fin;
   logic [IW-1:0] i;
   logic last, commit, ovf_fin, sgn;
`ifdef SEQ_MUL_SIGNED_EN
   logic sgn_q, neg_q;
   logic sgn_in;
   assign sgn_in = signed_op;
   assign a_in = sgn_in && a[BITS-1] ? -a : a;
   assign b_in = sgn_in && b[BITS-1] ? -b : b;
   assign sgn = sgn_q;
`else
   assign a_in = a;
   assign b_in = b;
   assign sgn = 1'b0 & signed_op;
`endif
   assign last = i == IW'(BITS-1);
   assign acc_add = acc + (b_q[i] ? ({{BITS{1'b0}}, a_q} << i) : '0);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (start) state_nx = RUN;
      else if (state == RUN && last) state_nx = sgn ? FIX : IDLE;
      else if (state == FIX) state_nx = IDLE;
   end
   always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
      fin = state == FIX ? (neg_q ? -acc : acc) : acc_add;
`else
      fin = acc_add;
`endif
      commit = !start && ((state == RUN && last && !sgn) || state == FIX);
      ovf_fin = sgn ? fin[2*BITS-1:BITS] != {BITS{fin[BITS-1]}} : |fin[2*BITS-1:BITS];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
         i <= '0;
         p <= '0;
         hi <= '0;
         ovf <= 1'b0;
         rdy <= 1'b0;
      end else if (start) begin
         a_q <= a_in;
         b_q <= b_in;
         acc <= '0;
         i <= '0;
         rdy <= 1'b0;
      end else begin
         if (state == RUN) begin
            acc <= acc_add;
            i <= i + 1'b1;
         end
         if (commit) begin
            p <= fin[BITS-1:0];
            hi <= fin[2*BITS-1:BITS];
            ovf <= ovf_fin;
            rdy <= 1'b1;
         end
      end
`ifdef SEQ_MUL_SIGNED_EN
   // Sign bookkeeping is only touched on a start edge.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sgn_q <= 1'b0;
         neg_q <= 1'b0;
      end else if (start) begin
         sgn_q <= sgn_in;
         neg_q <= sgn_in && (a[BITS-1] ^ b[BITS-1]);
      end
`endif
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: scoreboard bench for seq_mul at BITS = 8; follows SEQ_MUL_SIGNED_EN if defined.
module tb_seq_mul;
   logic clk = 1'b0, rst = 1'b1, signed_op = 1'b0, start = 1'b0;
   logic [7:0] a = '0, b = '0, p, hi;
   logic ovf, rdy;
   int cyc = 0, s_edge = 0, checks = 0, errors = 0;
   logic [7:0] last_p = '0, last_hi = '0;
   logic last_ovf = 1'b0;
   typedef struct {logic [7:0] p; logic [7:0] hi; logic ovf; int lat;} exp_t;
   exp_t sb[$];

   seq_mul #(.BITS(8)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .signed_op(signed_op),
      .start(start), .p(p), .hi(hi), .ovf(ovf), .rdy(rdy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
      exp_t e;
      int prod;
      prod = int'(x) * int'(y);
      e.ovf = prod > 255;
      e.lat = 8;
`ifdef SEQ_MUL_SIGNED_EN
      if (s) begin
         prod = int'($signed(x)) * int'($signed(y));
         e.ovf = prod > 127 || prod < -128;
         e.lat = 9;
      end
`else
      if (s) e.lat = 8;
`endif
      e.p = prod[7:0];
      e.hi = prod[15:8];
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
      @(negedge clk);
      a = x;
      b = y;
      signed_op = s;
      start = 1'b1;
      sb.delete();
      sb.push_back(model(x, y, s));
      @(posedge clk);
      #1;
      s_edge = cyc;
      chk("rdy_low_at_start", rdy, 0);
   endtask

   task automatic wait_done();
      exp_t e;
      int n = 0;
      while (!rdy && n < 20) begin
         tick();
         n++;
      end
      if (!rdy) chk("timeout", 0, 1);
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
         e = sb.pop_front();
         chk("latency", cyc - s_edge, e.lat);
         chk("p", p, e.p);
         chk("hi", hi, e.hi);
         chk("ovf", ovf, e.ovf);
         last_p = e.p;
         last_hi = e.hi;
         last_ovf = e.ovf;
      end
   endtask

   initial begin
      #2;
      chk("rst_p", p, 0);
      chk("rst_hi", hi, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rdy", rdy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      chk("rdy_low_after_rst", rdy, 0);
      launch(8'd13, 8'd11, 1'b0); wait_done();
      repeat (3) tick();
      chk("idle_rdy", rdy, 1);
      chk("idle_p", p, last_p);
      launch(8'd255, 8'd255, 1'b0); wait_done();
      launch(8'd0, 8'd200, 1'b0); wait_done();
      launch(8'hFD, 8'h05, 1'b1); wait_done();
`ifdef SEQ_MUL_SIGNED_EN
      launch(8'h80, 8'hFF, 1'b1); wait_done();
      launch(8'h80, 8'h80, 1'b1); wait_done();
      launch(8'h07, 8'hF9, 1'b1); wait_done();
`endif
      launch(8'd37, 8'd150, 1'b0); wait_done();
      launch(8'd7, 8'd9, 1'b0);
      repeat (2) tick();
      launch(8'd2, 8'd3, 1'b0); wait_done();
      launch(8'd5, 8'd6, 1'b0);
      repeat (7) tick();
      chk("b2b_rdy_pre", rdy, 0);
      launch(8'd10, 8'd20, 1'b0);
      chk("b2b_p_hold", p, last_p);
      chk("b2b_hi_hold", hi, last_hi);
      chk("b2b_ovf_hold", ovf, last_ovf);
      wait_done();
      launch(8'd9, 8'd9, 1'b0);
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      chk("async_rst_p", p, 0);
      chk("async_rst_hi", hi, 0);
      chk("async_rst_ovf", ovf, 0);
      chk("async_rst_rdy", rdy, 0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      tick();
      launch(8'd4, 8'd4, 1'b0); wait_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_mul.md
# seq_mul

Sequential shift-and-add integer multiplier: the multiplicative counterpart to the calculator's sequential divider, with the same start/rdy handshake. One operand bit is processed per clock, and the block produces a full double-width product. The calculator core uses it for its multiply operation so that the datapath sits on the same multi-cycle arithmetic slot as division. An optional signed mode is selected at compile time.

## Interface
- `BITS`, default 32: operand width; the product is 2·BITS wide. Legal range is 2 and above.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  BITS  multiplicand; sampled only on a start edge.
- `b`  in  BITS  multiplier; sampled only on a start edge.
- `signed_op`  in  1  selects two's-complement operation; sampled on a start edge. It is ignored unless `SEQ_MUL_SIGNED_EN` is defined.
- `start`  in  1  launches an operation; one-cycle pulse.
- `p`  out  BITS  low half of the product.
- `hi`  out  BITS  high half of the product.
- `ovf`  out  1  the product does not fit in BITS bits.
- `rdy`  out  1  results are valid and the block is idle.

## Operation
- States are IDLE, RUN and FIX. FIX exists only when `SEQ_MUL_SIGNED_EN` is defined.
- Reset (async, any state):
  - State goes to IDLE.
  - `p`, `hi`, `ovf`, `rdy` all clear to 0.
  - The internal accumulator and counter clear to 0.
  - `rdy` stays 0 after reset until the first operation completes.
- `start` has priority in every state, including RUN and FIX. On a start edge the block:
  - latches the operands;
  - clears the 2·BITS accumulator;
  - sets counter `i` to 0;
  - drives `rdy` to 0;
  - enters RUN.
  
  An in-flight operation is abandoned without completing.
- RUN, one edge per iteration:
  - If the latched multiplier bit `i` is 1, add (multiplicand zero-extended to 2·BITS) << `i` to the accumulator. The addition is modulo 2^(2·BITS).
  - Increment `i`.
  - On the edge where `i` equals BITS−1:
    - unsigned: commit `p`/`hi`/`ovf`, set `rdy`, go to IDLE;
    - signed: go to FIX.
- Unsigned results:
  - {`hi`,`p`} = a·b, exact.
  - `ovf` = 1 when `hi` ≠ 0.
- Signed mode (macro defined and `signed_op` = 1):
  - On the start edge the block latches the magnitudes |a| and |b| as BITS-bit unsigned values. The magnitude of −2^(BITS−1) is 2^(BITS−1), which is representable.
  - It also latches `neg` = a[BITS−1] XOR b[BITS−1].
  - FIX, one edge: if `neg`, replace the accumulator with its two's-complement negation. Then commit the outputs, set `rdy`, and go to IDLE.
  - `ovf` = 1 when `hi` is not all copies of `p`[BITS−1].
- Outputs `p`, `hi` and `ovf` change only on the commit edge. They hold their last values through a later operation until that operation commits.
- While `rdy` = 0, the outputs are stale and must not be consumed.
- Operand ports may change freely after the start edge.

## Timing
- Let edge S be the rising edge where `start` = 1. `rdy` is 0 from edge S onward.
- Unsigned: results commit and `rdy` rises at edge S+BITS.
- Signed: results commit and `rdy` rises at edge S+BITS+1.
- A start at edge S+BITS, the same edge as a commit, wins: `rdy` stays 0 and the outputs keep their previous values.
- Holding `start` high restarts the block every edge; `rdy` never rises while it is held.
- In IDLE, `rdy` stays 1 indefinitely and the outputs stay stable.
- Deasserting `rst` takes effect at the next edge; a start may be accepted on the first edge after deassertion.
- Throughput: one operation per BITS cycles (unsigned) or per BITS+1 cycles (signed), with back-to-back starts allowed on the commit edge.

## Configuration
- `SEQ_MUL_SIGNED_EN`:
  - Defined: `signed_op` is honoured; the magnitude/sign latch and the FIX state are built; signed latency is BITS+1.
  - Undefined: the port exists but is ignored; every operation is unsigned with latency BITS; FIX and the negation logic are not synthesized.
  - Unsigned behaviour and latency are identical in both builds.

## Test plan
All scenarios use BITS = 8.
- Unsigned 13×11: start → `rdy` at S+8; `p`=0x8F, `hi`=0x00, `ovf`=0.
- Unsigned 255×255: `p`=0x01, `hi`=0xFE, `ovf`=1. Also 0×200: `p`=0, `hi`=0, `ovf`=0.
- Signed mode (macro defined):
  - −3×5: `rdy` at S+9; `p`=0xF1, `hi`=0xFF, `ovf`=0.
  - −128×−1: `p`=0x80, `hi`=0x00, `ovf`=1.
  
  With the macro undefined, `signed_op`=1 with 0xFD×0x05 gives `p`=0xF1, `hi`=0x04, `ovf`=1 at S+8.
- Restart: start 7×9, then at S+3 start 2×3 → `rdy` low until S+3+8, then `p`=0x06, `hi`=0, `ovf`=0. The 7×9 result never appears.
- Reset mid-RUN: assert `rst` asynchronously at S+4 → `rdy`, `p`, `hi`, `ovf` go to 0 immediately, before the next edge. After release, 4×4 gives `p`=0x10.
- Back-to-back: a second start on the commit edge of the first → `rdy` stays 0 and the first result is not committed. The second result commits 8 edges later.
